// File: rtl/job_sequencer_pkg.sv
// Shared types and defaults for the job sequencer.
// Provides the FSM state encoding and default widths/timeout.
package job_sequencer_pkg;

    localparam int IDX_W_DEF   = 10;
    localparam int TIMEOUT_DEF = 1000000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PULSE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/job_sequencer_if.sv
// Handshake bundle between controller, sequencer and compute core.
// master: sequencer side (drives start/file_index/status); slave: environment.
interface job_sequencer_if
    import job_sequencer_pkg::*;
    #(parameter int IDX_W = IDX_W_DEF);

    logic             go;
    logic             abort;
    logic             finish;
    logic             start;
    logic [IDX_W-1:0] file_index;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic [IDX_W-1:0] jobs_done;

    modport master (
        input  go, abort, finish,
        output start, file_index, busy, done, err_timeout, jobs_done
    );

    modport slave (
        output go, abort, finish,
        input  start, file_index, busy, done, err_timeout, jobs_done
    );

endinterface

// File: rtl/job_sequencer_edge_detect_rise.sv
// Rising-edge detector: rise = d & ~d_q.
// Ports: clk, rst (async high), d in, rise out.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/job_sequencer.sv
// Steps file_index over FIRST_IDX..LAST_IDX, pulsing start per job.
// Ports: clk, rst (async high), bus (go/abort/finish in; start/status out).
module job_sequencer
    import job_sequencer_pkg::*;
#(
    parameter int IDX_W        = IDX_W_DEF,
    parameter int FIRST_IDX    = 0,
    parameter int LAST_IDX     = 2,
    parameter int START_CYCLES = 2,
    parameter int TO_W         = 20,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    job_sequencer_if.master  bus
);

    localparam int PC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(START_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] I_FIRST = IDX_W'(FIRST_IDX);
    localparam logic [IDX_W-1:0] I_LAST  = IDX_W'(LAST_IDX);
    localparam logic [IDX_W-1:0] I_ONE   = IDX_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

    state_t           state, state_nxt;
    logic             start_r, start_nxt;
    logic [IDX_W-1:0] idx_r, idx_nxt;
    logic [IDX_W-1:0] jobs_r, jobs_nxt;
    logic             err_r, err_nxt;
    logic [PC_W-1:0]  pc, pc_nxt;
    logic [TO_W-1:0]  to_cnt, to_nxt;
    logic             fin_seen, seen_nxt;
    logic             fin_rise;

    edge_detect_rise u_fin (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.finish),
        .rise (fin_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            start_r  <= 1'b0;
            idx_r    <= I_FIRST;
            jobs_r   <= '0;
            err_r    <= 1'b0;
            pc       <= '0;
            to_cnt   <= '0;
            fin_seen <= 1'b0;
        end else begin
            state    <= state_nxt;
            start_r  <= start_nxt;
            idx_r    <= idx_nxt;
            jobs_r   <= jobs_nxt;
            err_r    <= err_nxt;
            pc       <= pc_nxt;
            to_cnt   <= to_nxt;
            fin_seen <= seen_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_nxt = start_r;
        idx_nxt   = idx_r;
        jobs_nxt  = jobs_r;
        err_nxt   = err_r;
        pc_nxt    = pc;
        to_nxt    = to_cnt;
        seen_nxt  = fin_seen;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (bus.go) begin
                    state_nxt = S_PULSE;
                    start_nxt = 1'b1;
                    idx_nxt   = I_FIRST;
                    jobs_nxt  = '0;
                    err_nxt   = 1'b0;
                    pc_nxt    = '0;
                    seen_nxt  = 1'b0;
                end
            end
            S_PULSE: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                    start_nxt = 1'b0;
                end else begin
                    // A core that finishes while start is still high must
                    // not be lost; remember it for the WAIT state.
                    if (fin_rise) seen_nxt = 1'b1;
                    if (pc == PC_LAST) begin
                        state_nxt = S_WAIT;
                        start_nxt = 1'b0;
                        to_nxt    = '0;
                    end else begin
                        pc_nxt = pc + PC_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (fin_seen || fin_rise) begin
                    state_nxt = S_NEXT;
                    jobs_nxt  = jobs_r + I_ONE;
                end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                end else if (to_cnt != '1) begin
                    to_nxt = to_cnt + TO_ONE;
                end
            end
            S_NEXT: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (idx_r == I_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_PULSE;
                    start_nxt = 1'b1;
                    idx_nxt   = idx_r + I_ONE;
                    pc_nxt    = '0;
                    seen_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                start_nxt = 1'b0;
            end
        endcase
    end

    assign bus.start       = start_r;
    assign bus.file_index  = idx_r;
    assign bus.jobs_done   = jobs_r;
    assign bus.err_timeout = err_r;
    assign bus.busy        = (state == S_PULSE) || (state == S_WAIT)
                          || (state == S_NEXT);
    assign bus.done        = (state == S_DONE);

endmodule

// File: tb/tb_job_sequencer.sv
// Directed self-checking bench for job_sequencer.
// Uses LAST_IDX=2, START_CYCLES=2, TIMEOUT=50.
module tb_job_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    job_sequencer_if #(.IDX_W(10)) bus ();

    job_sequencer #(
        .IDX_W        (10),
        .FIRST_IDX    (0),
        .LAST_IDX     (2),
        .START_CYCLES (2),
        .TO_W         (20),
        .TIMEOUT      (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered in the first PULSE cycle of job idx; core finishes
    // 30 cycles after start falls. Leaves in next PULSE or in DONE.
    task automatic do_job(input int idx, input bit last);
        bus.finish = 1'b0;
        chk("job_start_c1", 32'(bus.start), 1);
        chk("job_index", 32'(bus.file_index), 32'(idx));
        chk("job_busy", 32'(bus.busy), 1);
        tick();
        chk("job_start_c2", 32'(bus.start), 1);
        tick();
        chk("job_start_low", 32'(bus.start), 0);
        repeat (29) tick();
        chk("job_wait_jobs", 32'(bus.jobs_done), 32'(idx));
        bus.finish = 1'b1;
        tick();
        chk("job_next_jobs", 32'(bus.jobs_done), 32'(idx + 1));
        chk("job_next_start", 32'(bus.start), 0);
        tick();
        if (last) begin
            chk("batch_done", 32'(bus.done), 1);
            chk("batch_busy", 32'(bus.busy), 0);
        end else begin
            chk("next_start", 32'(bus.start), 1);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.go     = 1'b0;
        bus.abort  = 1'b0;
        bus.finish = 1'b0;
        #2;
        chk("rst_start", 32'(bus.start), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err_timeout), 0);
        chk("rst_jobs", 32'(bus.jobs_done), 0);
        chk("rst_idx", 32'(bus.file_index), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_start", 32'(bus.start), 0);

        // Batch 0..2 with a well-behaved core.
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        do_job(0, 0);
        do_job(1, 0);
        do_job(2, 1);
        chk("t1_jobs", 32'(bus.jobs_done), 3);
        chk("t1_err", 32'(bus.err_timeout), 0);
        chk("t1_idx", 32'(bus.file_index), 2);
        tick();
        chk("t1_done_hold", 32'(bus.done), 1);

        // Finish level held across the job boundary.
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        chk("t2_restart_jobs", 32'(bus.jobs_done), 0);
        chk("t2_restart_done", 32'(bus.done), 0);
        do_job(0, 0);
        chk("t2_j1_idx", 32'(bus.file_index), 1);
        tick();
        tick();
        repeat (20) tick();
        chk("t2_stale_jobs", 32'(bus.jobs_done), 1);
        chk("t2_stale_busy", 32'(bus.busy), 1);
        chk("t2_stale_start", 32'(bus.start), 0);
        chk("t2_stale_idx", 32'(bus.file_index), 1);
        bus.finish = 1'b0;
        tick();
        chk("t2_low_jobs", 32'(bus.jobs_done), 1);
        bus.finish = 1'b1;
        tick();
        chk("t2_rise_jobs", 32'(bus.jobs_done), 2);
        tick();
        do_job(2, 1);
        chk("t2_jobs", 32'(bus.jobs_done), 3);

        // Finish pulse while start is high, then abort in WAIT.
        bus.finish = 1'b0;
        tick();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        chk("t3_start", 32'(bus.start), 1);
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        chk("t3_start_c2", 32'(bus.start), 1);
        tick();
        chk("t3_wait_start", 32'(bus.start), 0);
        chk("t3_wait_jobs", 32'(bus.jobs_done), 0);
        tick();
        chk("t3_next_jobs", 32'(bus.jobs_done), 1);
        chk("t3_next_start", 32'(bus.start), 0);
        tick();
        chk("t3_restart", 32'(bus.start), 1);
        chk("t3_idx", 32'(bus.file_index), 1);
        tick();
        tick();
        repeat (5) tick();
        chk("t5_pre_busy", 32'(bus.busy), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t5_start", 32'(bus.start), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_done", 32'(bus.done), 0);
        chk("t5_jobs", 32'(bus.jobs_done), 1);
        chk("t5_idx", 32'(bus.file_index), 1);
        tick();
        chk("t5_idle", 32'(bus.busy), 0);
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        chk("t5_go_idx", 32'(bus.file_index), 0);
        chk("t5_go_jobs", 32'(bus.jobs_done), 0);

        // Timeout on job 1.
        do_job(0, 0);
        chk("t4_idx", 32'(bus.file_index), 1);
        tick();
        tick();
        repeat (49) tick();
        chk("t4_pre_err", 32'(bus.err_timeout), 0);
        chk("t4_pre_busy", 32'(bus.busy), 1);
        tick();
        chk("t4_err", 32'(bus.err_timeout), 1);
        chk("t4_done", 32'(bus.done), 1);
        chk("t4_jobs", 32'(bus.jobs_done), 1);
        chk("t4_file", 32'(bus.file_index), 1);

        // Async reset in the middle of PULSE.
        bus.finish = 1'b0;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        chk("t6_err_clr", 32'(bus.err_timeout), 0);
        chk("t6_start", 32'(bus.start), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_start", 32'(bus.start), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_done", 32'(bus.done), 0);
        chk("t6_rst_idx", 32'(bus.file_index), 0);
        chk("t6_rst_jobs", 32'(bus.jobs_done), 0);
        #2;
        rst = 1'b0;
        tick();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        do_job(0, 0);
        do_job(1, 0);
        do_job(2, 1);
        chk("t6_jobs", 32'(bus.jobs_done), 3);
        chk("t6_err", 32'(bus.err_timeout), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
